// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM request/response front-end.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_ctrl.sv
// Front-end for a single-port synchronous RAM: single-beat writes, wrapping
// burst reads, read data returned over a backpressurable response channel.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // Both channels: a beat transfers on a rising edge where valid && ready;
  // valid never waits on ready, and the producer holds its fields until then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // The RAM address register doubles as the burst address pointer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ram_addr_d = req_addr;
          cnt_d      = req_len;
          if (req_we) begin
            ram_wdata_d = req_wdata;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_WR: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        ram_en  = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rsp_data_d = ram_rdata;
        rsp_last_d = (cnt_q == '0);
        state_d    = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d      = cnt_q - LEN_W'(1);
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            state_d    = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) && rst_n;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural RAM beside the DUT, reference memory model,
// expected queues for responses and RAM accesses, directed and random phases.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [LW-1:0] req_len = '0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  state_e        dbg_state;

  logic man_ready = 1'b1;
  logic rand_ready = 1'b0;
  logic rnd_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end
  assign rsp_ready = rand_ready ? rnd_ready : man_ready;

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  // Synchronous single-port RAM: read data appears the cycle after the strobe.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [DW:0]      exp_q[$];      // {last, data}
  logic [AW+DW:0]   exp_ram_q[$];  // {we, addr, wdata}
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (unexpected event) at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    logic [DW:0]    e;
    logic [AW+DW:0] r;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) fail_now("rsp_unexpected");
      else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
        check("rsp_last", 32'(rsp_last), 32'(e[DW]));
      end
    end
    if (ram_en === 1'b1) begin
      if (exp_ram_q.size() == 0) fail_now("ram_access_unexpected");
      else begin
        r = exp_ram_q.pop_front();
        check("ram_we", 32'(ram_we), 32'(r[AW+DW]));
        check("ram_addr", 32'(ram_addr), 32'(r[AW+DW-1:DW]));
        if (r[AW+DW]) check("ram_wdata", 32'(ram_wdata), 32'(r[DW-1:0]));
      end
    end
    if (ram_we === 1'b1) check("ram_we_needs_en", 32'(ram_en), 32'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [LW-1:0] len, input bit keep, output int hs);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_len = len; req_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      fail_now("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    if (we) begin
      ref_mem[addr] = wdata;
      exp_ram_q.push_back({1'b1, addr, wdata});
    end else begin
      for (int j = 0; j <= int'(len); j++) begin
        a = addr + AW'(j);
        exp_ram_q.push_back({1'b0, a, {DW{1'b0}}});
        exp_q.push_back({(j == int'(len)), ref_mem[a]});
      end
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    req_addr = AW'($urandom); req_wdata = DW'($urandom); req_len = LW'($urandom);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_now("idle_timeout");
  endtask

  task automatic wait_negedge_at(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs, hs2, at;
    logic [DW-1:0] beat2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_ready", 32'(req_ready), 32'd1);

    // single write then single-beat read back
    do_req(1'b1, 8'h10, 8'hA5, 8'd0, 1'b0, hs);
    @(negedge clk);
    check("wr_pulse_we", 32'(ram_we), 32'd1);
    @(negedge clk);
    check("wr_pulse_end", 32'(ram_we), 32'd0);
    check("wr_ready_c2", 32'(req_ready), 32'd1);
    do_req(1'b0, 8'h10, 8'h00, 8'd0, 1'b0, hs);
    @(negedge clk);
    check("rd_en_c1", 32'(ram_en), 32'd1);
    @(negedge clk);
    check("rd_valid_c2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_c3", 32'(rsp_valid), 32'd1);
    check("rd_data_c3", 32'(rsp_data), 32'hA5);
    check("rd_last_c3", 32'(rsp_last), 32'd1);
    @(negedge clk);
    check("rd_idle_c4", 32'(req_ready), 32'd1);

    // wrapping burst across the top of the address space
    do_req(1'b1, 8'hFE, 8'h11, 8'd0, 1'b0, hs);
    do_req(1'b1, 8'hFF, 8'h22, 8'd0, 1'b0, hs);
    do_req(1'b1, 8'h00, 8'h33, 8'd0, 1'b0, hs);
    do_req(1'b1, 8'h01, 8'h44, 8'd0, 1'b0, hs);
    do_req(1'b0, 8'hFE, 8'h00, 8'd3, 1'b0, hs);
    wait_idle(100, at);
    check("wrap_burst_len", 32'(at - hs), 32'd13);

    // stall on beat 2 of a 3-beat burst
    beat2 = ref_mem[8'hFF];
    do_req(1'b0, 8'hFE, 8'h00, 8'd2, 1'b0, hs);
    wait_negedge_at(hs + 5);
    @(posedge clk); #1 man_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'(beat2));
      check("stall_last", 32'(rsp_last), 32'd0);
      check("stall_no_ram", 32'(ram_en), 32'd0);
    end
    @(posedge clk); #1 man_ready = 1'b1;
    wait_idle(100, at);
    check("stall_latency", 32'(at - hs), 32'd15);

    // reset while beat 2 of 4 is presented
    do_req(1'b0, 8'hFE, 8'h00, 8'd3, 1'b0, hs);
    wait_negedge_at(hs + 5);
    @(posedge clk); #1;
    man_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    exp_q.delete();
    exp_ram_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    man_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_ram_en", 32'(ram_en), 32'd0);

    // request held valid throughout a burst is taken on the first idle cycle
    do_req(1'b0, 8'hFF, 8'h00, 8'd1, 1'b1, hs);
    do_req(1'b1, 8'h20, 8'h5C, 8'd0, 1'b0, hs2);
    check("held_req_accept", 32'(hs2 - hs), 32'd7);

    // full-array fill and full-length wrapping read under random backpressure
    for (int a = 0; a < DEPTH; a++) begin
      do_req(1'b1, AW'(a), DW'(a) ^ 8'h5A, 8'd0, 1'b0, hs);
    end
    rand_ready = 1'b1;
    do_req(1'b0, 8'h80, 8'h00, 8'd255, 1'b0, hs);
    wait_idle(6000, at);

    // random mix
    for (int t = 0; t < 40; t++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
             LW'($urandom_range(0, 7)), 1'b0, hs);
    end
    wait_idle(400, at);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_ram_q.size() != 0); i++) @(negedge clk);
    check("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("ram_queue_drained", 32'(exp_ram_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
